// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with occupancy count, level flags, sticky errors and flush
module fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             Clr,
  input  logic [WIDTH-1:0] Din,
  input  logic             Wen,
  input  logic             Ren,
  output logic [WIDTH-1:0] Dout,
  output logic             Dvalid,
  output logic             Fempty,
  output logic             Ffull,
  output logic             Faempty,
  output logic             Fafull,
  output logic [AW:0]      Count,
  output logic             Ovf,
  output logic             Udf
);
  localparam logic [AW:0] CFULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CAF   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] CAE   = (AW+1)'(AE_LEVEL);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             rd_ok, wr_ok;
  logic [AW:0]      cnt_n;
  // acceptance decided on pre-edge state; a read frees the slot a full-FIFO write needs
  always_comb begin
    rd_ok = ~Clr & Ren & (Count != '0);
    wr_ok = ~Clr & Wen & ((Count != CFULL) | rd_ok);
    cnt_n = Count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  end
  // storage array, never cleared; writes suppressed while reset is held
  always_ff @(posedge ck)
    if (wr_ok & ~rst) mem[wp] <= Din;
  // pointers, count, registered flags and sticky error bits
  always_ff @(posedge ck or posedge rst)
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      Count   <= '0;
      Fempty  <= 1'b1;
      Ffull   <= 1'b0;
      Faempty <= 1'b1;
      Fafull  <= 1'b0;
      Dout    <= '0;
      Dvalid  <= 1'b0;
      Ovf     <= 1'b0;
      Udf     <= 1'b0;
    end else if (Clr) begin
      wp      <= '0;
      rp      <= '0;
      Count   <= '0;
      Fempty  <= 1'b1;
      Ffull   <= 1'b0;
      Faempty <= 1'b1;
      Fafull  <= 1'b0;
      Dvalid  <= 1'b0;
      Ovf     <= 1'b0;
      Udf     <= 1'b0;
    end else begin
      wp      <= wr_ok ? wp + 1'b1 : wp;
      rp      <= rd_ok ? rp + 1'b1 : rp;
      Dout    <= rd_ok ? mem[rp] : Dout;
      Dvalid  <= rd_ok;
      Count   <= cnt_n;
      Fempty  <= cnt_n == '0;
      Ffull   <= cnt_n == CFULL;
      Faempty <= cnt_n <= CAE;
      Fafull  <= cnt_n >= CAF;
      Ovf     <= Ovf | (Wen & ~wr_ok);
      Udf     <= Udf | (Ren & ~rd_ok);
    end
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: randomized and directed scoreboard bench for fifo_param
module tb_fifo_param;
  logic       ck = 0, rst = 1, Clr = 0, Wen = 0, Ren = 0;
  logic [7:0] Din = 0, Dout;
  logic       Dvalid, Fempty, Ffull, Faempty, Fafull, Ovf, Udf;
  logic [4:0] Count;
  int         total = 0, bad = 0;
  int         q[$];
  int         exp_q[$];
  int         exp_dout = 0;
  bit         exp_dv = 0, m_ovf = 0, m_udf = 0;

  fifo_param #(.WIDTH(8), .DEPTH(16), .AW(4), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .ck(ck), .rst(rst), .Clr(Clr), .Din(Din), .Wen(Wen), .Ren(Ren), .Dout(Dout),
    .Dvalid(Dvalid), .Fempty(Fempty), .Ffull(Ffull), .Faempty(Faempty), .Fafull(Fafull),
    .Count(Count), .Ovf(Ovf), .Udf(Udf));

  always #5 ck = ~ck;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic check_state();
    int n = q.size();
    check("count", int'(Count), n);
    check("flags {empty,full,aempty,afull,ovf,udf,dvalid}",
          int'({Fempty, Ffull, Faempty, Fafull, Ovf, Udf, Dvalid}),
          int'({n == 0, n == 16, n <= 4, n >= 12, m_ovf, m_udf, exp_dv}));
    check("dout", int'(Dout), exp_dout);
  endtask

  task automatic cyc(input bit w, input bit r, input bit c, input logic [7:0] d);
    bit rd, wr;
    Wen = w; Ren = r; Clr = c; Din = d;
    @(posedge ck);
    if (c) begin
      q.delete(); m_ovf = 0; m_udf = 0; exp_dv = 0;
    end else begin
      rd = r && q.size() > 0;
      wr = w && (q.size() < 16 || rd);
      if (rd) begin
        exp_dout = q.pop_front();
        exp_q.push_back(exp_dout);
      end
      if (wr) q.push_back(int'(d));
      if (w && !wr) m_ovf = 1;
      if (r && !rd) m_udf = 1;
      exp_dv = rd;
    end
    #1;
    check_state();
    Wen = 0; Ren = 0; Clr = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    q.delete(); exp_q.delete();
    exp_dout = 0; exp_dv = 0; m_ovf = 0; m_udf = 0;
    #1;
    check_state();
    @(posedge ck);
    #1;
    rst = 0;
  endtask

  // monitor: every Dvalid pulse must deliver the next word the model released
  always @(negedge ck)
    if (!rst && Dvalid) begin
      if (exp_q.size() == 0) check("unexpected dvalid", 1, 0);
      else check("scoreboard dout", int'(Dout), exp_q.pop_front());
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge ck); #1;
    rst = 0;
    check_state();
    // fill / drain
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'(i));
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 8'h00);
    // wrap
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 8'(8'h30 + i));
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 8'h00);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 8'(8'hA0 + i));
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 8'h00);
    // full with simultaneous read and write
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'(8'h10 + i));
    cyc(1, 1, 0, 8'h55);
    // overflow, then drain to 7 and flush
    cyc(1, 0, 0, 8'hEE);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 1, 8'h00);
    cyc(1, 0, 0, 8'h77);
    cyc(0, 1, 0, 8'h00);
    // underflow, empty with read and write
    cyc(0, 1, 0, 8'h00);
    cyc(1, 1, 0, 8'h66);
    cyc(0, 1, 0, 8'h00);
    // reset mid-stream
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'(8'hC0 + i));
    cyc(0, 1, 0, 8'h00);
    do_reset();
    // randomized phases with varying write/read bias
    for (int p = 0; p < 8; p++) begin
      int pw = (p % 2) ? 30 : 75;
      int pr = (p % 2) ? 75 : 35;
      for (int i = 0; i < 250; i++)
        cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
            $urandom_range(0, 99) < 2, 8'($urandom));
      if (p == 4) do_reset();
    end
    for (int i = 0; i < 17; i++) cyc(0, 1, 0, 8'h00);
    @(negedge ck); #1;
    check("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
